uart_rx: RTL

- Asynchronous serial receiver for the CPU's UART_RX pin: 8N1 format (1 start, 8 data LSB-first, 1 stop), no parity.
- It is the receive counterpart of the existing UART transmitter that drives UART_TX.
- It presents each received byte in a holding register with a valid flag that the peripheral bus reads and acknowledges.
- It reports framing and overrun errors as sticky status bits.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and baud divider math.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks.
// Held at zero while clear is high so a new frame starts phase-aligned.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote,
// a read-acknowledged holding register and sticky framing/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;

    logic       sync1_q, rx_s_q;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       s6_q, s6_d;
    logic       s7_q, s7_d;
    logic       brk_q, brk_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic tick;
    logic decide;
    logic wrap;
    logic maj;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign decide = tick && (scnt_q == 4'd8);
    assign wrap   = tick && (scnt_q == 4'd15);
    assign maj    = (s6_q & s7_q) | (s6_q & rx_s_q) | (s7_q & rx_s_q);

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        s6_d        = s6_q;
        s7_d        = s7_q;
        brk_d       = brk_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (state_q == IDLE) begin
            scnt_d = '0;
        end else if (tick) begin
            scnt_d = scnt_q + 4'd1;
        end

        if (tick && scnt_q == 4'd6) begin
            s6_d = rx_s_q;
        end
        if (tick && scnt_q == 4'd7) begin
            s7_d = rx_s_q;
        end

        if (rd_ack) begin
            rx_valid_d = 1'b0;
        end
        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                brk_d = 1'b0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (wrap) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // After a bad stop bit, wait out a BREAK before re-arming.
                if (brk_q) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                        brk_d   = 1'b0;
                    end
                end else if (decide) begin
                    if (maj) begin
                        state_d    = IDLE;
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rd_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            scnt_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            s6_q        <= 1'b1;
            s7_q        <= 1'b1;
            brk_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            scnt_q      <= scnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            s6_q        <= s6_d;
            s7_q        <= s7_d;
            brk_q       <= brk_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
